// File: rtl/serial_add_pkg.sv
// serial_add_pkg
//   Shared definitions for the bit-serial adder controller: the FSM state
//   type and the default operand width.
package serial_add_pkg;

    // Default operand/result width. The legal range is 2..32.
    localparam int WIDTH_DEF = 8;

    // Controller states. The fourth encoding is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage : serial_add_pkg

// File: rtl/fullAdder.sv
// fullAdder
//   Single-bit full-adder cell.
//   Ports:
//     a, b   : operand bits
//     cin    : carry in
//     s      : sum bit
//     cout   : carry out
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : fullAdder

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder: {cout,sum} = a + b + cin, computed LSB first with one
//   fullAdder cell, one bit per clock.
//
//   Timing (start accepted at edge 0):
//     edges 1..WIDTH : one sum bit per edge, busy high for WIDTH cycles
//     edge WIDTH     : FSM enters DONE, final carry captured into cout
//     edge WIDTH+1   : done pulses for one cycle, FSM back in IDLE
//   A start held high is therefore accepted every WIDTH+2 cycles.
//
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     start  : operation request, only sampled in IDLE
//     a, b   : operands, captured on accepted start
//     cin    : carry in, captured on accepted start
//     sub    : (SERIAL_ADD_SUB_EN only) 1 = compute a - b, cin ignored,
//              cout=1 means no borrow
//     busy   : operation in progress
//     done   : one-cycle result-valid pulse
//     sum    : result, holds until the next accepted start
//     cout   : final carry, holds with sum
//
//   Configuration macro: SERIAL_ADD_SUB_EN adds the sub input.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter only has to reach WIDTH-1; it wraps on the last RUN cycle.
    localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_co;

    // Operand conditioning at capture time. Subtraction stores ~b and seeds
    // the carry with 1, so the serial datapath is identical for both modes.
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADD_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    fullAdder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = RUN;
                end
            end

            RUN: begin
                // Sum bits enter at the MSB and walk right, so after WIDTH
                // shifts bit 0 of the result sits in sum[0].
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Publish the final carry now so cout matches the carry
                    // flop for the whole DONE cycle.
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered flags: busy tracks the next state, done is DONE delayed
        // by one edge so it lands in the cycle where IDLE can take a new start.
        busy_d = (state_d == RUN);
        done_d = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : serial_add_ctrl

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request an operation; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, captured on accepted start.
REQ-006 b  input  WIDTH  operand B, captured on accepted start.
REQ-007 cin  input  1  carry-in, captured on accepted start.
REQ-008 busy  output  1  high from the cycle after accepted start until done.
REQ-009 done  output  1  single-cycle pulse when sum/cout are valid.
REQ-010 sum  output  WIDTH  result register; holds until the next accepted start.
REQ-011 cout  output  1  final carry-out; holds with sum.

Function
REQ-012 The block shall compute {cout,sum} = a + b + cin bit-serially with one full-adder cell, LSB first, one bit per cycle.
REQ-013 FSM states shall be IDLE, RUN, DONE; any unused encoding shall return to IDLE.
REQ-014 IDLE: start=1 shall load a, b into shift registers, load cin into the carry flop, clear the bit counter, clear sum, and go to RUN.
REQ-015 RUN: each cycle shall shift the full-adder sum bit into sum[WIDTH-1] (right shift), register carry-out into the carry flop, and increment the counter.
REQ-016 RUN shall last exactly WIDTH cycles, then go to DONE; in DONE, cout shall equal the carry flop.
REQ-017 DONE shall assert done for exactly one cycle and return to IDLE.
REQ-018 Latency: start sampled at edge 0 -> done high during the cycle following edge WIDTH+1; back-to-back start may be accepted the cycle after done.
REQ-019 start while busy or done shall be ignored; no queueing.
REQ-020 Changes to a, b, or cin after acceptance shall not affect the result.
REQ-021 Overflow shall wrap modulo 2^WIDTH in sum, with the carry reported only in cout.

Reset
REQ-022 rst_n low shall immediately force IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0.
REQ-023 Reset mid-RUN shall abandon the operation; no done pulse shall follow reset release.
REQ-024 The first start after reset release shall be accepted normally.

Configuration
REQ-025 Macro SERIAL_ADD_SUB_EN: when defined, add input port sub (1 bit, captured with start); sub=1 shall compute a + ~b + 1 (cin ignored), and cout=1 shall mean no borrow.
REQ-026 Without SERIAL_ADD_SUB_EN, port sub shall be absent and the block shall add only.

Structure
REQ-027 Shared package serial_add_pkg shall hold the FSM state typedef (IDLE/RUN/DONE) and the WIDTH default constant.
REQ-028 The block shall instantiate the existing fullAdder cell exactly once as its only sub-module; the controller shall add no other adder logic.

Verification (WIDTH=8)
REQ-029 a=0x0F, b=0x01, cin=0, pulse start -> done high 9 cycles after the start edge; sum=0x10, cout=0.
REQ-030 a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1; busy high for exactly 8 cycles.
REQ-031 start pulse mid-RUN with different operands -> ignored; first result unchanged; only one done pulse.
REQ-032 rst_n low at RUN cycle 4 -> all outputs 0 immediately; no done after release; next start (0x22+0x11) -> 0x33.
REQ-033 Back-to-back starts (start held high) -> operations accepted every 10 cycles; each result correct.
REQ-034 With SERIAL_ADD_SUB_EN: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0; a=0x07, b=0x05 -> sum=0x02, cout=1.
